// File: rtl/spi_sched_pkg.sv
// Shared definitions for the SPI transmitter scheduler.
// Holds the one-hot FSM encoding and the default timing parameters.
package spi_sched_pkg;

    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_SETUP_CYC = 2;
    localparam int unsigned DEF_TIMEOUT   = 1023;

    // One-hot scheduler states
    typedef enum logic [6:0] {
        IDLE      = 7'b000_0001,
        SETUP     = 7'b000_0010,
        START     = 7'b000_0100,
        WAIT_LOW  = 7'b000_1000,
        WAIT_HIGH = 7'b001_0000,
        DONE      = 7'b010_0000,
        ERR       = 7'b100_0000
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     - request vector
//   last    - index of the most recently served requester
//   gnt_c   - one-hot winner (first asserted request after last, wrapping)
//   idx_c   - index of the winner
//   valid_c - at least one request asserted
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             valid_c
);

    // Search last+1, last+2, ... modulo N_REQ; the first hit wins
    always_comb begin
        int unsigned k;
        k       = 0;
        gnt_c   = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            k = (32'(last) + i) % N_REQ;
            if (!valid_c && req[IDX_W'(k)]) begin
                valid_c          = 1'b1;
                gnt_c[IDX_W'(k)] = 1'b1;
                idx_c            = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/spi_scheduler.sv
// Round-robin scheduler sharing one SPI master transmitter among N_REQ clients.
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   req                 - level request per client
//   req_data            - client i word at [i*DATA_W +: DATA_W]
//   req_ckp, req_cph    - per-client clock polarity / phase
//   gnt                 - one-hot grant, held for the whole transaction
//   done, err           - one-cycle completion / timeout pulse per client
//   busy                - high whenever the FSM is not IDLE
//   tx_data, CKP, CPH   - latched word and mode of the winner, to the transmitter
//   start_stb           - one-cycle start pulse to the transmitter
//   CS                  - transmitter chip select (active low), sampled registered
module spi_scheduler
    import spi_sched_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_ckp,
    input  logic [N_REQ-1:0]        req_cph,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic                    busy,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    start_stb,
    output logic                    CKP,
    output logic                    CPH,
    input  logic                    CS
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t             state;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic               cs_q;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   win;
    logic [N_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req),
        .last    (last),
        .gnt_c   (arb_gnt),
        .idx_c   (arb_idx),
        .valid_c (arb_valid)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and shared setup/timeout counter
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE:      if (arb_valid) state_d = SETUP;
            SETUP:     if (cnt == CNT_W'(SETUP_CYC)) state_d = START;
            START:     state_d = WAIT_LOW;
            // CS is tested before the timeout so an edge on the last cycle still succeeds
            WAIT_LOW:  begin
                if (!cs_q)                         state_d = WAIT_HIGH;
                else if (cnt == CNT_W'(TIMEOUT))   state_d = ERR;
            end
            WAIT_HIGH: begin
                if (cs_q)                          state_d = DONE;
                else if (cnt == CNT_W'(TIMEOUT))   state_d = ERR;
            end
            DONE:      state_d = IDLE;
            ERR:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        // Clear on every state change, otherwise count up and saturate
        if (state_d != state) begin
            cnt_d = '0;
        end else if (cnt != CNT_W'(TIMEOUT)) begin
            cnt_d = cnt + CNT_W'(1);
        end
    end

    // Registered outputs, transaction latches and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            cs_q      <= 1'b1;
            last      <= IDX_W'(N_REQ - 1);
            win       <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            busy      <= 1'b0;
            start_stb <= 1'b0;
            tx_data   <= '0;
            CKP       <= 1'b0;
            CPH       <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            cs_q      <= CS;
            busy      <= (state_d != IDLE);
            start_stb <= (state_d == START);
            done      <= '0;
            err       <= '0;
            if (state == IDLE && state_d == SETUP) begin
                win     <= arb_idx;
                gnt     <= arb_gnt;
                tx_data <= req_data[32'(arb_idx) * DATA_W +: DATA_W];
                CKP     <= req_ckp[arb_idx];
                CPH     <= req_cph[arb_idx];
            end
            if (state_d == DONE) done <= gnt;
            if (state_d == ERR)  err  <= gnt;
            // Winner drops to lowest priority once its transaction closes
            if (state == DONE || state == ERR) begin
                gnt  <= '0;
                last <= win;
            end
        end
    end

endmodule

// File: tb/tb_spi_scheduler.sv
// Directed self-checking bench for spi_scheduler with a simple transmitter model.
module tb_spi_scheduler;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 16;

    localparam int W_GNT    = 0;
    localparam int W_START  = 1;
    localparam int W_DONE   = 2;
    localparam int W_DONERR = 3;
    localparam int W_CSLOW  = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ckp;
    logic [N_REQ-1:0]        req_cph;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic [N_REQ-1:0]        err;
    logic                    busy;
    logic [DATA_W-1:0]       tx_data;
    logic                    start_stb;
    logic                    CKP;
    logic                    CPH;
    logic                    cs_pin;
    logic                    cs_model;
    logic                    cs_man;
    int                      tx_mode;   // 0 normal, 1 never lowers CS, 2 manual CS

    int checks = 0;
    int errors = 0;

    spi_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .req_ckp   (req_ckp),
        .req_cph   (req_cph),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .tx_data   (tx_data),
        .start_stb (start_stb),
        .CKP       (CKP),
        .CPH       (CPH),
        .CS        (cs_pin)
    );

    always #5 clk = ~clk;

    assign cs_pin = (tx_mode == 2) ? cs_man : cs_model;

    // Transmitter model: CS low one edge after start_stb, held low for 8 edges
    initial begin : xmtr
        cs_model = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_mode == 0 && start_stb === 1'b1) begin
                @(posedge clk);
                #1 cs_model = 1'b0;
                repeat (8) @(posedge clk);
                #1 cs_model = 1'b1;
            end
        end
    end

    // Bounded wait on a DUT event; cyc = negedges until seen, -1 if never
    task automatic wait_for(input int what, input int limit, output int cyc);
        cyc = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if ((what == W_GNT    && gnt != '0) ||
                (what == W_START  && start_stb === 1'b1) ||
                (what == W_DONE   && done != '0) ||
                (what == W_DONERR && (done != '0 || err != '0)) ||
                (what == W_CSLOW  && cs_pin === 1'b0)) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, done, err, busy, start_stb, CKP, CPH} !== 15'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0", {gnt, done, err, busy, start_stb, CKP, CPH});
        end
        checks++;
        if (tx_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_tx_data: got %h want 0000", tx_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_single;
        int c;
        req = 4'b0001;
        wait_for(W_GNT, 5, c);
        checks++;
        if (c !== 1 || gnt !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt: cyc %0d gnt %b busy %b want 1 0001 1", c, gnt, busy);
        end
        checks++;
        if (tx_data !== 16'h0509 || CKP !== 1'b0) begin
            errors++;
            $display("FAIL single_latch: got %h/%b want 0509/0", tx_data, CKP);
        end
        wait_for(W_START, 10, c);
        checks++;
        if (c !== 3) begin
            errors++;
            $display("FAIL single_start_lat: got %0d want 3", c);
        end
        wait_for(W_DONERR, 40, c);
        checks++;
        if (c !== 11 || done !== 4'b0001 || err !== 4'b0000) begin
            errors++;
            $display("FAIL single_done: cyc %0d done %b err %b want 11 0001 0000", c, done, err);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (done !== 4'b0000 || busy !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_after: done %b busy %b gnt %b want 0000 0 0000", done, busy, gnt);
        end
    endtask

    task automatic test_round_robin;
        logic [N_REQ-1:0] exp_order [4];
        int c;
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b1000;
        exp_order[3] = 4'b0001;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        req = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            wait_for(W_GNT, 5, c);
            checks++;
            if (c !== 1 || gnt !== exp_order[i]) begin
                errors++;
                $display("FAIL rr_gnt%0d: cyc %0d gnt %b want 1 %b", i, c, gnt, exp_order[i]);
            end
            wait_for(W_DONE, 40, c);
            checks++;
            if (c !== 14 || done !== exp_order[i]) begin
                errors++;
                $display("FAIL rr_done%0d: cyc %0d done %b want 14 %b", i, c, done, exp_order[i]);
            end
            if (i == 3) req = 4'b0000;
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle%0d: gnt %b busy %b want 0000 0", i, gnt, busy);
            end
        end
    endtask

    task automatic test_mode_switch;
        int c;
        req = 4'b0001;
        wait_for(W_GNT, 5, c);
        wait_for(W_DONE, 40, c);
        checks++;
        if (done !== 4'b0001) begin
            errors++;
            $display("FAIL mode_done0: got %b want 0001", done);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (tx_data !== 16'h0509 || CKP !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mode_hold: got %h/%b/%b want 0509/0/0", tx_data, CKP, busy);
        end
        req = 4'b0100;
        wait_for(W_GNT, 5, c);
        checks++;
        if (gnt !== 4'b0100 || CKP !== 1'b1 || CPH !== 1'b0 || tx_data !== 16'h2222) begin
            errors++;
            $display("FAIL mode_latch: gnt %b ckp %b cph %b data %h want 0100 1 0 2222", gnt, CKP, CPH, tx_data);
        end
        wait_for(W_START, 10, c);
        checks++;
        if (c < 2 || CKP !== 1'b1) begin
            errors++;
            $display("FAIL mode_setup: cyc %0d ckp %b want >=2 1", c, CKP);
        end
        wait_for(W_CSLOW, 5, c);
        checks++;
        if (c === -1 || CKP !== 1'b1) begin
            errors++;
            $display("FAIL mode_sck_idle: cyc %0d ckp %b want 1", c, CKP);
        end
        wait_for(W_DONE, 40, c);
        checks++;
        if (done !== 4'b0100) begin
            errors++;
            $display("FAIL mode_done2: got %b want 0100", done);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int c;
        tx_mode = 1;
        req = 4'b0001;
        wait_for(W_GNT, 5, c);
        wait_for(W_START, 10, c);
        // counter runs 0..1023 from the cycle after START, ERR follows
        wait_for(W_DONERR, 1100, c);
        checks++;
        if (c !== 1025 || err !== 4'b0001 || done !== 4'b0000 || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_err: cyc %0d err %b done %b gnt %b want 1025 0001 0000 0001", c, err, done, gnt);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || err !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_clear: gnt %b busy %b err %b want 0000 0 0000", gnt, busy, err);
        end
        tx_mode = 0;
        req = 4'b0010;
        wait_for(W_GNT, 5, c);
        checks++;
        if (gnt !== 4'b0010 || tx_data !== 16'h1111) begin
            errors++;
            $display("FAIL timeout_next_gnt: gnt %b data %h want 0010 1111", gnt, tx_data);
        end
        wait_for(W_DONERR, 40, c);
        checks++;
        if (c !== 14 || done !== 4'b0010) begin
            errors++;
            $display("FAIL timeout_next_done: cyc %0d done %b want 14 0010", c, done);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_timeout_boundary;
        int  c;
        logic seen_err;
        tx_mode = 2;
        cs_man = 1'b1;
        req = 4'b1000;
        wait_for(W_GNT, 5, c);
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL bound_gnt: got %b want 1000", gnt);
        end
        wait_for(W_START, 10, c);
        // CS falls so its registered copy lands on the counter's TIMEOUT cycle
        repeat (1023) @(posedge clk);
        #1 cs_man = 1'b0;
        seen_err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (err != '0) seen_err = 1'b1;
        end
        checks++;
        if (seen_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bound_no_err: err_seen %b busy %b want 0 1", seen_err, busy);
        end
        cs_man = 1'b1;
        wait_for(W_DONERR, 10, c);
        checks++;
        if (done !== 4'b1000 || err !== 4'b0000) begin
            errors++;
            $display("FAIL bound_done: done %b err %b want 1000 0000", done, err);
        end
        req = 4'b0000;
        tx_mode = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int  c;
        logic seen;
        req = 4'b0100;
        wait_for(W_GNT, 5, c);
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL rmid_gnt: got %b want 0100", gnt);
        end
        wait_for(W_CSLOW, 10, c);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({gnt, done, err, busy, start_stb, CKP, CPH} !== 15'h0 || tx_data !== 16'h0) begin
            errors++;
            $display("FAIL rmid_async: ctrl %b data %h want 0 0000", {gnt, done, err, busy, start_stb, CKP, CPH}, tx_data);
        end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done != '0 || err != '0) seen = 1'b1;
        end
        reset = 1'b0;
        req = 4'b0101;
        wait_for(W_GNT, 5, c);
        checks++;
        if (seen !== 1'b0 || c !== 1 || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_restart: pulse %b cyc %0d gnt %b want 0 1 0001", seen, c, gnt);
        end
        wait_for(W_DONERR, 40, c);
        checks++;
        if (done !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_done: got %b want 0001", done);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_req_drop;
        int c;
        req = 4'b0010;
        wait_for(W_GNT, 5, c);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL drop_gnt: got %b want 0010", gnt);
        end
        wait_for(W_CSLOW, 10, c);
        repeat (3) @(negedge clk);
        req = 4'b0000;
        wait_for(W_DONERR, 30, c);
        checks++;
        if (done !== 4'b0010 || err !== 4'b0000) begin
            errors++;
            $display("FAIL drop_done: done %b err %b want 0010 0000", done, err);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL drop_idle: busy %b gnt %b want 0 0000", busy, gnt);
        end
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        tx_mode  = 0;
        cs_man   = 1'b1;
        req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0509};
        req_ckp  = 4'b0100;
        req_cph  = 4'b0000;
        test_reset;
        test_single;
        test_round_robin;
        test_mode_switch;
        test_timeout;
        test_timeout_boundary;
        test_reset_mid;
        test_req_drop;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
